// File: rtl/fp_addsub_seq.sv
// Multi-cycle IEEE-754 add/subtract, parametrised by exponent/fraction width; subnormals flush to zero.
// Latency: 2 cycles for NaN/inf operands, 6+k otherwise (k = one-bit left-normalise steps).
// Backpressure: none; start is ignored while busy and can be re-accepted the cycle after done.
module fp_addsub_seq #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 op,
    input  logic [EXP_W+MAN_W:0] a,
    input  logic [EXP_W+MAN_W:0] b,
    output logic                 busy,
    output logic                 done,
    output logic [EXP_W+MAN_W:0] result,
    output logic                 ovf,
    output logic                 unf,
    output logic                 inv
);
    localparam int SW = MAN_W + 4;  // hidden bit + fraction + guard, round, sticky
    localparam int MSB = EXP_W + MAN_W;
    localparam logic [EXP_W-1:0] EXP_ONES = '1;
    localparam logic [EXP_W-1:0] SW_E = EXP_W'(SW);
    localparam logic [EXP_W:0] EXP_ONE = (EXP_W+1)'(1);

    typedef enum logic [2:0] {
        S_IDLE, S_UNPACK, S_ALIGN, S_ADD, S_NORM, S_ROUND, S_FINISH
    } state_t;

    state_t state, state_nxt;

    logic [MSB:0]     a_r, b_r;
    logic             op_r;
    logic             sa_r, sb_r;
    logic [EXP_W-1:0] ea_r, eb_r;
    logic [SW-1:0]    ma_r, mb_r;
    logic [EXP_W:0]   exp_r;
    logic [SW:0]      acc_r;
    logic             sign_r, eff_sub_r, zero_neg_r, flush_r;

    logic [EXP_W-1:0] ea_u, eb_u;
    logic [MAN_W-1:0] fa_u, fb_u;
    logic             sb_eff, nan_a, nan_b, inf_a, inf_b, special;

    assign ea_u    = a_r[MSB-1:MAN_W];
    assign eb_u    = b_r[MSB-1:MAN_W];
    assign fa_u    = a_r[MAN_W-1:0];
    assign fb_u    = b_r[MAN_W-1:0];
    assign sb_eff  = b_r[MSB] ^ op_r;
    assign nan_a   = (ea_u == EXP_ONES) && (fa_u != '0);
    assign nan_b   = (eb_u == EXP_ONES) && (fb_u != '0);
    assign inf_a   = (ea_u == EXP_ONES) && (fa_u == '0);
    assign inf_b   = (eb_u == EXP_ONES) && (fb_u == '0);
    assign special = nan_a | nan_b | inf_a | inf_b;

    logic             a_big, s_big;
    logic [EXP_W-1:0] e_big, e_small, d;
    logic [SW-1:0]    m_big, m_small, m_sh;

    always_comb begin
        a_big   = {ea_r, ma_r} >= {eb_r, mb_r};
        e_big   = a_big ? ea_r : eb_r;
        e_small = a_big ? eb_r : ea_r;
        m_big   = a_big ? ma_r : mb_r;
        m_small = a_big ? mb_r : ma_r;
        s_big   = a_big ? sa_r : sb_r;
        d       = e_big - e_small;
        if (d >= SW_E) begin
            m_sh = {{(SW-1){1'b0}}, |m_small};
        end else begin
            m_sh    = m_small >> d;
            m_sh[0] = m_sh[0] | (|(m_small & ~({SW{1'b1}} << d)));
        end
    end

    logic           rnd_up, exp_gt1;
    logic [MAN_W:0] frac_sum;
    logic [EXP_W:0] exp_rnd;

    always_comb begin
        exp_gt1  = exp_r > EXP_ONE;
        // Nearest-even: round up on G when R|S is set or the kept LSB is odd.
        rnd_up   = acc_r[2] & (acc_r[3] | acc_r[1] | acc_r[0]);
        frac_sum = {1'b0, acc_r[SW-2:3]} + {{MAN_W{1'b0}}, rnd_up};
        exp_rnd  = exp_r + {{EXP_W{1'b0}}, frac_sum[MAN_W]};
    end

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b1;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) state_nxt = S_UNPACK;
            end
            S_UNPACK: state_nxt = special ? S_FINISH : S_ALIGN;
            S_ALIGN:  state_nxt = S_ADD;
            S_ADD:    state_nxt = S_NORM;
            S_NORM: begin
                if (acc_r[SW] || acc_r == '0 || acc_r[SW-1] || !exp_gt1) state_nxt = S_ROUND;
            end
            S_ROUND:  state_nxt = S_FINISH;
            S_FINISH: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_r <= '0; b_r <= '0; op_r <= 1'b0;
            sa_r <= 1'b0; sb_r <= 1'b0; ea_r <= '0; eb_r <= '0; ma_r <= '0; mb_r <= '0;
            exp_r <= '0; acc_r <= '0; sign_r <= 1'b0; eff_sub_r <= 1'b0;
            zero_neg_r <= 1'b0; flush_r <= 1'b0;
            result <= '0; ovf <= 1'b0; unf <= 1'b0; inv <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_r <= a; b_r <= b; op_r <= op;
                        ovf <= 1'b0; unf <= 1'b0; inv <= 1'b0; flush_r <= 1'b0;
                    end
                end
                S_UNPACK: begin
                    sa_r <= a_r[MSB];
                    sb_r <= sb_eff;
                    ea_r <= ea_u;
                    eb_r <= eb_u;
                    ma_r <= (ea_u == '0) ? '0 : {1'b1, fa_u, 3'b000};
                    mb_r <= (eb_u == '0) ? '0 : {1'b1, fb_u, 3'b000};
                    if (nan_a || nan_b || (inf_a && inf_b && a_r[MSB] != sb_eff)) begin
                        result <= {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};
                        inv    <= 1'b1;
                    end else if (inf_a) begin
                        result <= {a_r[MSB], EXP_ONES, {MAN_W{1'b0}}};
                    end else if (inf_b) begin
                        result <= {sb_eff, EXP_ONES, {MAN_W{1'b0}}};
                    end
                end
                S_ALIGN: begin
                    exp_r      <= {1'b0, e_big};
                    sign_r     <= s_big;
                    eff_sub_r  <= sa_r ^ sb_r;
                    zero_neg_r <= sa_r & sb_r;
                    ma_r       <= m_big;
                    mb_r       <= m_sh;
                end
                S_ADD: begin
                    acc_r <= eff_sub_r ? ({1'b0, ma_r} - {1'b0, mb_r})
                                       : ({1'b0, ma_r} + {1'b0, mb_r});
                end
                S_NORM: begin
                    if (acc_r[SW]) begin
                        acc_r <= {1'b0, acc_r[SW:2], acc_r[1] | acc_r[0]};
                        exp_r <= exp_r + EXP_ONE;
                    end else if (acc_r != '0 && !acc_r[SW-1]) begin
                        if (exp_gt1) begin
                            acc_r <= acc_r << 1;
                            exp_r <= exp_r - EXP_ONE;
                        end else begin
                            acc_r   <= '0;
                            flush_r <= 1'b1;
                            unf     <= 1'b1;
                        end
                    end
                end
                S_ROUND: begin
                    if (acc_r == '0) begin
                        result <= {flush_r ? sign_r : zero_neg_r, {(EXP_W+MAN_W){1'b0}}};
                    end else if (exp_rnd >= {1'b0, EXP_ONES}) begin
                        result <= {sign_r, EXP_ONES, {MAN_W{1'b0}}};
                        ovf    <= 1'b1;
                    end else begin
                        result <= {sign_r, exp_rnd[EXP_W-1:0], frac_sum[MAN_W-1:0]};
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fp_addsub_seq.sv
// Bench for fp_addsub_seq: SP and DP instances, directed corner cases plus random operands
// checked against an exact big-integer reference of add/sub with flush-to-zero and nearest-even rounding.
`timescale 1ns/1ps
module tb_fp_addsub_seq;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        sp_start, sp_op, sp_busy, sp_done, sp_ovf, sp_unf, sp_inv;
    logic [31:0] sp_a, sp_b, sp_result;
    logic        dp_start, dp_op, dp_busy, dp_done, dp_ovf, dp_unf, dp_inv;
    logic [63:0] dp_a, dp_b, dp_result;

    fp_addsub_seq #(.EXP_W(8), .MAN_W(23)) u_sp (
        .clk(clk), .reset(reset), .start(sp_start), .op(sp_op), .a(sp_a), .b(sp_b),
        .busy(sp_busy), .done(sp_done), .result(sp_result), .ovf(sp_ovf), .unf(sp_unf), .inv(sp_inv));

    fp_addsub_seq #(.EXP_W(11), .MAN_W(52)) u_dp (
        .clk(clk), .reset(reset), .start(dp_start), .op(dp_op), .a(dp_a), .b(dp_b),
        .busy(dp_busy), .done(dp_done), .result(dp_result), .ovf(dp_ovf), .unf(dp_unf), .inv(dp_inv));

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic dut_done(input bit dp);
        return dp ? dp_done : sp_done;
    endfunction
    function automatic logic dut_busy(input bit dp);
        return dp ? dp_busy : sp_busy;
    endfunction
    function automatic logic [63:0] dut_res(input bit dp);
        return dp ? dp_result : {32'h0, sp_result};
    endfunction
    function automatic logic [2:0] dut_flags(input bit dp);
        return dp ? {dp_ovf, dp_unf, dp_inv} : {sp_ovf, sp_unf, sp_inv};
    endfunction

    task automatic drive(input bit dp, input logic s, input logic o, input logic [63:0] x, input logic [63:0] y);
        if (dp) begin
            dp_start = s; dp_op = o; dp_a = x; dp_b = y;
        end else begin
            sp_start = s; sp_op = o; sp_a = x[31:0]; sp_b = y[31:0];
        end
    endtask

    // Waits until idle, issues one operation, returns result, {ovf,unf,inv} and edges-to-done.
    task automatic run_op(input bit dp, input logic o, input logic [63:0] x, input logic [63:0] y,
                          output logic [63:0] res, output logic [2:0] flg, output int lat);
        int guard = 0;
        while (dut_busy(dp) && guard < 200) begin
            @(posedge clk); #1; guard++;
        end
        @(negedge clk); drive(dp, 1'b1, o, x, y);
        @(posedge clk); #1; drive(dp, 1'b0, ~o, ~x, ~y);
        lat = 1;
        while (!dut_done(dp) && lat < 100) begin
            @(posedge clk); #1; lat++;
        end
        check("done_seen", 64'(dut_done(dp)), 64'd1);
        res = dut_res(dp);
        flg = dut_flags(dp);
    endtask

    // Exact reference: operands as scaled big integers, exact sum, then normalise/round once.
    function automatic logic [63:0] ref_fp(input logic [63:0] a, input logic [63:0] b, input logic op,
                                           input int ew, input int mw, output logic [2:0] flg);
        int emax, ea, eb, emin, p, e, sh;
        logic [63:0] mmask, fa, fb, kept;
        logic sa, sb, rs, nan_a, nan_b, inf_a, inf_b;
        logic [2111:0] va, vb, m, rem, half;
        emax  = (1 << ew) - 1;
        mmask = (64'd1 << mw) - 64'd1;
        ea = int'((a >> mw) & 64'(emax));
        eb = int'((b >> mw) & 64'(emax));
        fa = a & mmask;
        fb = b & mmask;
        sa = a[ew+mw];
        sb = b[ew+mw] ^ op;
        flg = 3'b000;
        nan_a = (ea == emax) && (fa != 0);
        nan_b = (eb == emax) && (fb != 0);
        inf_a = (ea == emax) && (fa == 0);
        inf_b = (eb == emax) && (fb == 0);
        if (nan_a || nan_b || (inf_a && inf_b && sa != sb)) begin
            flg = 3'b001;
            return (64'(emax) << mw) | (64'd1 << (mw - 1));
        end
        if (inf_a) return (64'(sa) << (ew + mw)) | (64'(emax) << mw);
        if (inf_b) return (64'(sb) << (ew + mw)) | (64'(emax) << mw);
        va = '0;
        vb = '0;
        if (ea != 0) va[63:0] = fa | (64'd1 << mw);
        if (eb != 0) vb[63:0] = fb | (64'd1 << mw);
        emin = (ea < eb) ? ea : eb;
        va = va << (ea - emin);
        vb = vb << (eb - emin);
        if (sa == sb)      begin m = va + vb; rs = sa; end
        else if (va >= vb) begin m = va - vb; rs = sa; end
        else               begin m = vb - va; rs = sb; end
        if (m == 0) return 64'(sa & sb) << (ew + mw);
        p = 0;
        for (int i = 0; i < 2112; i++) if (m[i]) p = i;
        e = emin + p - mw;
        if (e < 1) begin
            flg = 3'b010;
            return 64'(rs) << (ew + mw);
        end
        if (p > mw) begin
            sh   = p - mw;
            kept = 64'(m >> sh);
            rem  = m & ((2112'(1) << sh) - 2112'(1));
            half = 2112'(1) << (sh - 1);
            if (rem > half || (rem == half && kept[0])) kept = kept + 64'd1;
            if (kept[mw+1]) begin
                kept = kept >> 1;
                e    = e + 1;
            end
        end else begin
            kept = 64'(m) << (mw - p);
        end
        if (e >= emax) begin
            flg = 3'b100;
            return (64'(rs) << (ew + mw)) | (64'(emax) << mw);
        end
        return (64'(rs) << (ew + mw)) | (64'(e) << mw) | (kept & mmask);
    endfunction

    function automatic logic [63:0] gen_op(input int ew, input int mw, input int near_e);
        int emax, e, kind;
        logic [63:0] f;
        emax = (1 << ew) - 1;
        kind = int'($urandom_range(0, 19));
        f    = {$urandom, $urandom} & ((64'd1 << mw) - 64'd1);
        if (kind == 0)      begin e = 0;    f = '0; end
        else if (kind == 1) begin e = emax; f = '0; end
        else if (kind == 2) begin e = emax; f[0] = 1'b1; end
        else if (kind == 3) begin e = 0;    f[0] = 1'b1; end
        else if (kind < 9)  e = int'($urandom_range(1, emax - 1));
        else begin
            e = near_e + int'($urandom_range(0, 8)) - 4;
            if (e < 1) e = 1;
            if (e > emax - 1) e = emax - 1;
        end
        return (64'($urandom_range(0, 1)) << (ew + mw)) | (64'(e) << mw) | f;
    endfunction

    typedef struct {
        logic        op;
        logic [31:0] a, b, res;
        logic [2:0]  flg;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    initial begin
        logic [63:0] res, x, y, expv;
        logic [2:0]  flg, eflg;
        logic        o;
        int          lat, cnt;

        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        drive(1'b1, 1'b0, 1'b0, '0, '0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_sp_busy", 64'(sp_busy), 64'd0);
        check("rst_sp_done", 64'(sp_done), 64'd0);
        check("rst_sp_res", 64'(sp_result), 64'd0);
        check("rst_sp_flags", 64'(dut_flags(1'b0)), 64'd0);
        check("rst_dp_res", dp_result, 64'd0);
        @(negedge clk); reset = 1'b0;

        // {op, a, b, result, {ovf,unf,inv}, latency (0 = not checked)}
        vecs.push_back('{1'b0, 32'h3F800000, 32'h3F800000, 32'h40000000, 3'b000, 6});
        vecs.push_back('{1'b1, 32'h3F800000, 32'h3F400000, 32'h3E800000, 3'b000, 8});
        vecs.push_back('{1'b1, 32'h3FC00000, 32'h3FC00000, 32'h00000000, 3'b000, 6});
        vecs.push_back('{1'b1, 32'h7F800000, 32'h7F800000, 32'h7FC00000, 3'b001, 2});
        vecs.push_back('{1'b0, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 3'b100, 0});
        vecs.push_back('{1'b0, 32'h3F800000, 32'h33800000, 32'h3F800000, 3'b000, 0});
        vecs.push_back('{1'b0, 32'h3F800001, 32'h33800000, 32'h3F800002, 3'b000, 0});
        vecs.push_back('{1'b0, 32'h80000000, 32'h80000000, 32'h80000000, 3'b000, 6});
        vecs.push_back('{1'b1, 32'h80000000, 32'h00000000, 32'h80000000, 3'b000, 0});
        vecs.push_back('{1'b0, 32'h00000000, 32'h80000000, 32'h00000000, 3'b000, 0});
        vecs.push_back('{1'b0, 32'h00400000, 32'h00000001, 32'h00000000, 3'b000, 0});
        vecs.push_back('{1'b1, 32'h00800001, 32'h00800000, 32'h00000000, 3'b010, 0});
        vecs.push_back('{1'b0, 32'hFF800000, 32'h3F800000, 32'hFF800000, 3'b000, 2});
        vecs.push_back('{1'b0, 32'h7FC12345, 32'h3F800000, 32'h7FC00000, 3'b001, 2});
        foreach (vecs[i]) begin
            run_op(1'b0, vecs[i].op, 64'(vecs[i].a), 64'(vecs[i].b), res, flg, lat);
            check("dir_res", res, 64'(vecs[i].res));
            check("dir_flags", 64'(flg), 64'(vecs[i].flg));
            if (vecs[i].lat != 0) check("dir_lat", 64'(lat), 64'(vecs[i].lat));
        end

        // Result and flags hold after the done pulse.
        repeat (3) @(posedge clk);
        #1;
        check("hold_done", 64'(sp_done), 64'd0);
        check("hold_res", 64'(sp_result), 64'h7FC00000);
        check("hold_flags", 64'(dut_flags(1'b0)), 64'd1);

        // Start pulsed while busy must be ignored and not queued.
        @(negedge clk); drive(1'b0, 1'b1, 1'b0, 64'h3F800000, 64'h3F800000);
        @(posedge clk); #1; drive(1'b0, 1'b0, 1'b0, '0, '0);
        lat = 1;
        while (!sp_done && lat < 100) begin
            drive(1'b0, lat == 3, 1'b1, 64'h40400000, 64'h3F800000);
            @(posedge clk); #1; lat++;
        end
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        check("busy_start_res", 64'(sp_result), 64'h40000000);
        check("busy_start_lat", 64'(lat), 64'd6);
        cnt = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (sp_busy) cnt++;
        end
        check("busy_start_not_queued", 64'(cnt), 64'd0);

        // Back-to-back: start raised during done is taken on the first IDLE cycle.
        run_op(1'b0, 1'b0, 64'h3F800000, 64'h3F800000, res, flg, lat);
        drive(1'b0, 1'b1, 1'b0, 64'h40000000, 64'h40000000);
        @(posedge clk); #1;
        check("b2b_idle", 64'(sp_busy), 64'd0);
        @(posedge clk); #1;
        check("b2b_accept", 64'(sp_busy), 64'd1);
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        lat = 1;
        while (!sp_done && lat < 100) begin
            @(posedge clk); #1; lat++;
        end
        check("b2b_res", 64'(sp_result), 64'h40800000);
        check("b2b_lat", 64'(lat), 64'd6);

        // Reset during a long normalisation aborts the operation.
        @(posedge clk); #1;
        @(negedge clk); drive(1'b0, 1'b1, 1'b1, 64'h3F800000, 64'h3F7FFFFF);
        @(posedge clk); #1; drive(1'b0, 1'b0, 1'b0, '0, '0);
        repeat (5) @(posedge clk);
        #1; reset = 1'b1;
        @(posedge clk); #1;
        check("rst_norm_busy", 64'(sp_busy), 64'd0);
        check("rst_norm_done", 64'(sp_done), 64'd0);
        check("rst_norm_res", 64'(sp_result), 64'd0);
        @(negedge clk); reset = 1'b0;
        cnt = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (sp_done || sp_busy) cnt++;
        end
        check("rst_norm_quiet", 64'(cnt), 64'd0);

        run_op(1'b1, 1'b0, 64'h3FF0000000000000, 64'h3FF0000000000000, res, flg, lat);
        check("dp_one_plus_one", res, 64'h4000000000000000);
        check("dp_lat", 64'(lat), 64'd6);
        check("dp_flags", 64'(flg), 64'd0);

        for (int i = 0; i < 300; i++) begin
            x = gen_op(8, 23, int'($urandom_range(1, 254)));
            if ($urandom_range(0, 3) == 0) y = x ^ 64'($urandom_range(0, 255));
            else                            y = gen_op(8, 23, int'(x[30:23]));
            o = 1'($urandom_range(0, 1));
            expv = ref_fp(x, y, o, 8, 23, eflg);
            run_op(1'b0, o, x, y, res, flg, lat);
            check("sp_rand_res", res, expv);
            check("sp_rand_flags", 64'(flg), 64'(eflg));
            check("sp_rand_lat_bound", 64'(lat <= 31), 64'd1);
        end
        for (int i = 0; i < 60; i++) begin
            x = gen_op(11, 52, int'($urandom_range(1, 2046)));
            if ($urandom_range(0, 3) == 0) y = x ^ 64'($urandom_range(0, 4095));
            else                            y = gen_op(11, 52, int'(x[62:52]));
            o = 1'($urandom_range(0, 1));
            expv = ref_fp(x, y, o, 11, 52, eflg);
            run_op(1'b1, o, x, y, res, flg, lat);
            check("dp_rand_res", res, expv);
            check("dp_rand_flags", 64'(flg), 64'(eflg));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
